// File: rtl/frame_payload_ctrl_pkg.sv
// rtl/frame_payload_ctrl_pkg.sv - shared types and defaults for the frame payload controller
// Purpose: capture FSM state encoding, payload FIFO entry layout, default
//          frame header byte and frame length.
// Ports:   none (package).
package frame_payload_ctrl_pkg;

  localparam logic [7:0] FRAMEHEAD_DEF  = 8'h47;
  localparam int         FRAMECOUNT_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2,
    ST_WAIT    = 2'd3
  } fpc_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } fifo_entry_t;

endpackage

// File: rtl/frame_commit_fifo.sv
// rtl/frame_commit_fifo.sv - payload FIFO with commit/rewind write side and FWFT read side
// Purpose: stores payload entries; only entries below commit_ptr are readable,
//          so a partially written frame can be discarded by rewinding.
// Ports:   clk, rst        - clock, synchronous active-high reset
//          wr_en, wr_entry - write one entry at wr_ptr
//          commit          - publish everything up to and including this cycle's write
//          rewind          - discard uncommitted entries (wr_ptr <= commit_ptr)
//          rd_ready        - consumer pops the head entry when rd_valid
//          rd_entry        - head entry (first-word fall-through)
//          rd_valid        - at least one committed entry is pending
//          free_space      - free entries, already accounting for a same-cycle rewind
module frame_commit_fifo
  import frame_payload_ctrl_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        commit,
  input  logic        rewind,
  input  logic        rd_ready,
  output fifo_entry_t rd_entry,
  output logic        rd_valid,
  output logic [AW:0] free_space
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  fifo_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_base;

  // A premature header rewinds and re-evaluates space in the same cycle,
  // so the space check must already see the rewound pointer.
  assign wr_base    = rewind ? commit_ptr : wr_ptr;
  assign free_space = DEPTH_W - (wr_base - rd_ptr);

  assign rd_valid = (commit_ptr != rd_ptr);
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rewind) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // commit is only raised together with the frame's last write
      if (commit) begin
        commit_ptr <= wr_ptr + 1'b1;
      end
      if (rd_valid && rd_ready) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_payload_ctrl.sv
// rtl/frame_payload_ctrl.sv - strips frame headers and queues whole payloads for a consumer
// Purpose: after a synchronizer-flagged header, capture PLEN payload bytes into
//          a commit FIFO; frames that do not fit or are cut short are dropped.
// Ports:   clk, rst             - clock, synchronous active-high reset
//          en                   - capture enable (low forces IDLE)
//          data, syn_flag       - byte stream and header marker
//          out_data/sof/eof     - head payload byte and frame boundary flags
//          out_valid, out_ready - FWFT handshake
//          locked               - headers arriving within LOSS_LIMIT cycles
//          frame_cnt, drop_cnt  - committed (wrapping) / dropped (saturating) frames
module frame_payload_ctrl
  import frame_payload_ctrl_pkg::*;
#(
  parameter int FRAMECOUNT = FRAMECOUNT_DEF,
  parameter int DEPTH      = 32,
  parameter int LOSS_LIMIT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data,
  input  logic        syn_flag,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int PLEN = FRAMECOUNT - 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(PLEN + 1);
  localparam int WW   = $clog2(LOSS_LIMIT + 1);

  localparam logic [CW-1:0] LAST_IDX = CW'(PLEN - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(LOSS_LIMIT);
  localparam logic [AW:0]   PLEN_W   = (AW+1)'(PLEN);

  fpc_state_e    state;
  logic [CW-1:0] byte_cnt;   // payload bytes already handled in this frame
  logic [WW-1:0] wd_cnt;     // cycles since the last syn_flag, stops at the limit

  logic          lock_lost;
  logic          last_byte;
  logic          room_ok;
  logic          wr_en;
  logic          commit;
  logic          rewind;
  logic [7:0]    drop_next;
  logic [AW:0]   free_space;
  fifo_entry_t   wr_entry;
  fifo_entry_t   rd_entry;

  // lock falls on the edge where the watchdog reaches LOSS_LIMIT
  assign lock_lost = !syn_flag && (wd_cnt == WD_LIMIT - 1'b1);
  assign last_byte = (byte_cnt == LAST_IDX);
  assign room_ok   = (free_space >= PLEN_W);
  assign drop_next = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 1'b1;

  assign wr_en    = (state == ST_PAYLOAD) && en && !syn_flag && !lock_lost;
  assign commit   = wr_en && last_byte;
  assign rewind   = (state == ST_PAYLOAD) && (!en || syn_flag || lock_lost);
  assign wr_entry = '{data: data, sof: (byte_cnt == '0), eof: last_byte};

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      locked <= 1'b0;
    end else if (syn_flag) begin
      wd_cnt <= '0;
      locked <= 1'b1;
    end else begin
      if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (lock_lost) begin
        locked <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (syn_flag) begin
            state    <= room_ok ? ST_PAYLOAD : ST_DROP;
            byte_cnt <= '0;
          end else if (lock_lost) begin
            state <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (!en || lock_lost) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            drop_cnt <= drop_next;
          end else if (syn_flag) begin
            // aborted frame is counted, flagged byte starts the next one
            state    <= room_ok ? ST_PAYLOAD : ST_DROP;
            byte_cnt <= '0;
            drop_cnt <= drop_next;
          end else if (last_byte) begin
            state     <= ST_WAIT;
            byte_cnt  <= '0;
            frame_cnt <= frame_cnt + 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        ST_DROP: begin
          if (!en) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            drop_cnt <= drop_next;
          end else if (syn_flag) begin
            state    <= room_ok ? ST_PAYLOAD : ST_DROP;
            byte_cnt <= '0;
            drop_cnt <= drop_next;
          end else if (last_byte) begin
            state    <= ST_WAIT;
            byte_cnt <= '0;
            drop_cnt <= drop_next;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          byte_cnt <= '0;
        end
      endcase
    end
  end

  frame_commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_entry   (wr_entry),
    .commit     (commit),
    .rewind     (rewind),
    .rd_ready   (out_ready),
    .rd_entry   (rd_entry),
    .rd_valid   (out_valid),
    .free_space (free_space)
  );

  assign out_data = rd_entry.data;
  assign out_sof  = rd_entry.sof;
  assign out_eof  = rd_entry.eof;

endmodule
